mult_div_unit: RTL

- Multicycle signed 32-bit multiply/divide unit for the MIPS datapath, executing mult and div into private Hi/Lo registers.
- Sits beside the ALU. Takes operands from the A and B register outputs and is started by the control unit.
- Its Hi and Lo outputs feed extra inputs of the register-bank write-data mux for mfhi and mflo.
- Also supports direct Hi/Lo writes for mthi and mtlo.

---
 rtl/mult_div_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed 32-bit multiply/divide into private Hi/Lo registers.
// Shift-add multiply and restoring divide run on magnitudes; signs are fixed up at FIN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_ma, r_mb, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc, w_acc, w_sh, w_prod;
    logic               r_op, r_neg_q, r_neg_r, r_dz, r_done, r_divzero;
    logic               w_last, w_bz;
    logic [WIDTH:0]     w_sum, w_diff;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q, w_r;

    assign w_bz    = (B == '0);
    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_abs_a = A[WIDTH-1] ? -A : A;
    assign w_abs_b = B[WIDTH-1] ? -B : B;

    // Multiply: add multiplicand to upper half when the low bit is set, then shift right.
    // Divide: shift left, trial-subtract the divisor from the upper half, set the quotient bit.
    always_comb begin
        w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_ma : {WIDTH{1'b0}})};
        w_sh   = {r_acc[2*WIDTH-2:0], 1'b0};
        w_diff = {1'b0, w_sh[2*WIDTH-1:WIDTH]} - {1'b0, r_mb};
        w_acc  = (r_state == DIV) ? (w_diff[WIDTH] ? w_sh : {w_diff[WIDTH-1:0], w_sh[WIDTH-1:1], 1'b1})
                                  : {w_sum, r_acc[WIDTH-1:1]};
        w_prod = r_neg_q ? -r_acc : r_acc;
        w_q    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_r    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (Start) w_next = Op ? (w_bz ? FIN : DIV) : MULT;
            MULT, DIV: if (w_last) w_next = FIN;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_ma      <= '0;
            r_mb      <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_op      <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            if (r_state == IDLE) begin
                if (HiWrite) r_hi <= WriteData;
                if (LoWrite) r_lo <= WriteData;
                if (Start) begin
                    r_ma    <= w_abs_a;
                    r_mb    <= w_abs_b;
                    r_op    <= Op;
                    r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                    r_neg_r <= A[WIDTH-1];
                    r_dz    <= Op && w_bz;
                    r_cnt   <= '0;
                    r_acc   <= {{WIDTH{1'b0}}, (Op ? w_abs_a : w_abs_b)};
                end
            end else if (r_state == FIN) begin
                r_done    <= 1'b1;
                r_divzero <= r_dz;
                if (!r_dz) begin
                    r_hi <= r_op ? w_r : w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= r_op ? w_q : w_prod[WIDTH-1:0];
                end
            end else begin
                r_acc <= w_acc;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign Hi      = r_hi;
    assign Lo      = r_lo;
    assign Busy    = (r_state != IDLE);
    assign Done    = r_done;
    assign DivZero = r_divzero;
endmodule
